hyperram_controller: RTL and testbench

Single-channel HyperRAM bus master that converts a 32-bit word read or write request into a HyperBus transaction (CS#, CK, DQ[7:0], RWDS). It sits between an on-chip requester and the external HyperRAM pads. It generates the 48-bit command/address, counts initial latency, transfers 4 bytes and enforces a programmable CS# recovery gap.

---
 rtl/hyperram_pkg.sv | 35 +++
 rtl/hyperram_io.sv | 33 +++
 rtl/hyperram_controller.sv | 211 +++++++++++++++++++++
 tb/tb_hyperram_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperram_pkg.sv
// Shared HyperRAM controller types: FSM state encoding, command/address layout and
// the helper that builds the 48-bit CA word.
package hyperram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_WAIT,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam int unsigned CA_BYTES     = 6;
    localparam int unsigned DATA_BYTES   = 4;

    localparam int unsigned CA_RW_BIT    = 47;
    localparam int unsigned CA_AS_BIT    = 46;
    localparam int unsigned CA_BURST_BIT = 45;
    localparam int unsigned CA_ROW_MSB   = 44;
    localparam int unsigned CA_ROW_LSB   = 16;
    localparam int unsigned CA_COL_MSB   = 2;

    // Reserved bits [15:3] stay zero.
    function automatic logic [47:0] build_ca(input logic i_we, input logic [31:0] i_addr);
        logic [47:0] ca;
        ca                         = '0;
        ca[CA_RW_BIT]              = ~i_we;
        ca[CA_AS_BIT]              = 1'b0;
        ca[CA_BURST_BIT]           = 1'b1;
        ca[CA_ROW_MSB:CA_ROW_LSB]  = i_addr[31:3];
        ca[CA_COL_MSB:0]           = i_addr[2:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperram_io.sv
// HyperBus pad slice: dq/rwds tri-state drivers, input pass-through and the
// registered rwds history used to detect read-strobe transitions.
module hyperram_io (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_dq_oe,
    input  logic [7:0] i_dq_o,
    input  logic       i_rwds_oe,
    input  logic       i_rwds_o,
    output logic [7:0] o_dq_i,
    output logic       o_rwds_i,
    output logic       o_rwds_edge,
    inout  wire  [7:0] io_dq,
    inout  wire        io_rwds
);

    logic r_rwds_prev;

    assign io_dq       = i_dq_oe   ? i_dq_o   : 8'hzz;
    assign io_rwds     = i_rwds_oe ? i_rwds_o : 1'bz;
    assign o_dq_i      = io_dq;
    assign o_rwds_i    = io_rwds;
    assign o_rwds_edge = (io_rwds != r_rwds_prev);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rwds_prev <= 1'b0;
        end else begin
            r_rwds_prev <= io_rwds;
        end
    end

endmodule

// File: rtl/hyperram_controller.sv
// Single-channel HyperBus master: one 32-bit word read or write per request.
// Define HYPERRAM_ASSERT_EN to compile in protocol assertions and covers.
module hyperram_controller
    import hyperram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        transaction_begin,
    input  logic        write_enable,
    input  logic        timed_read,
    input  logic [31:0] address,
    input  logic [3:0]  write_mask,
    input  logic [5:0]  wait_latency,
    input  logic [5:0]  done_latency,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        read_valid,
    output logic        busy,
    output logic        ck,
    output logic        cs_n,
    inout  wire  [7:0]  dq,
    inout  wire         rwds
);

    state_t      r_state;
    state_t      w_next;
    logic [47:0] r_ca;
    logic [31:0] r_wdata;
    logic [31:0] r_data_in;
    logic [23:0] r_rd_shift;
    logic [3:0]  r_mask;
    logic        r_we;
    logic        r_timed;
    logic        r_ck;
    logic        r_read_valid;
    logic [5:0]  r_wait_lat;
    logic [5:0]  r_done_lat;
    logic [5:0]  r_done_cnt;
    logic [7:0]  r_wait_cnt;
    logic [2:0]  r_cnt;

    logic        w_dq_oe;
    logic [7:0]  w_dq_o;
    logic [7:0]  w_dq_i;
    logic        w_rwds_oe;
    logic        w_rwds_o;
    logic        w_rwds_i;
    logic        w_rwds_edge;
    logic        w_step;
    logic        w_last;

    hyperram_io u_io (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_dq_oe     (w_dq_oe),
        .i_dq_o      (w_dq_o),
        .i_rwds_oe   (w_rwds_oe),
        .i_rwds_o    (w_rwds_o),
        .o_dq_i      (w_dq_i),
        .o_rwds_i    (w_rwds_i),
        .o_rwds_edge (w_rwds_edge),
        .io_dq       (dq),
        .io_rwds     (rwds)
    );

    assign data_in    = r_data_in;
    assign read_valid = r_read_valid;
    assign ck         = r_ck;
    assign busy       = (r_state != ST_IDLE);
    assign cs_n       = !(r_state inside {ST_CA, ST_WAIT, ST_DATA});

    // A data beat is a write byte, a timed read byte, or a read byte marked by an rwds transition.
    assign w_step = (r_state == ST_DATA) && (r_we || r_timed || w_rwds_edge);
    assign w_last = w_step && (r_cnt == 3'(DATA_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_dq_oe   = 1'b0;
        w_dq_o    = '0;
        w_rwds_oe = 1'b0;
        w_rwds_o  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (transaction_begin) w_next = ST_CA;
            end
            ST_CA: begin
                w_dq_oe = 1'b1;
                w_dq_o  = r_ca[47:40];
                if (r_cnt == 3'(CA_BYTES - 1)) begin
                    w_next = (r_wait_cnt == '0) ? ST_DATA : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_dq_oe = r_we;
                if (r_wait_cnt == 8'd1) w_next = ST_DATA;
            end
            ST_DATA: begin
                if (r_we) begin
                    w_dq_oe   = 1'b1;
                    w_dq_o    = r_wdata[31:24];
                    w_rwds_oe = 1'b1;
                    w_rwds_o  = r_mask[3];
                end
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (r_done_cnt <= 6'd1) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ca         <= '0;
            r_wdata      <= '0;
            r_data_in    <= '0;
            r_rd_shift   <= '0;
            r_mask       <= '0;
            r_we         <= 1'b0;
            r_timed      <= 1'b0;
            r_ck         <= 1'b0;
            r_read_valid <= 1'b0;
            r_wait_lat   <= '0;
            r_done_lat   <= '0;
            r_done_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_cnt        <= '0;
        end else begin
            r_read_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (transaction_begin) begin
                        r_ca       <= build_ca(write_enable, address);
                        r_wdata    <= data_out;
                        r_mask     <= write_mask;
                        r_we       <= write_enable;
                        r_timed    <= timed_read;
                        r_wait_lat <= wait_latency;
                        r_done_lat <= done_latency;
                        r_wait_cnt <= '0;
                        r_cnt      <= '0;
                        r_ck       <= 1'b1;
                    end
                end
                ST_CA: begin
                    r_ck  <= ~r_ck;
                    r_ca  <= {r_ca[39:0], 8'h00};
                    r_cnt <= (r_cnt == 3'(CA_BYTES - 1)) ? '0 : r_cnt + 3'd1;
                    // The memory flags doubled latency on rwds during the second CA byte.
                    if (r_cnt == 3'd1) begin
                        r_wait_cnt <= w_rwds_i ? {r_wait_lat, 2'b00} : {1'b0, r_wait_lat, 1'b0};
                    end
                end
                ST_WAIT: begin
                    r_ck       <= ~r_ck;
                    r_wait_cnt <= r_wait_cnt - 8'd1;
                end
                ST_DATA: begin
                    r_ck <= ~r_ck;
                    if (w_step) begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_wdata <= {r_wdata[23:0], 8'h00};
                        r_mask  <= {r_mask[2:0], 1'b0};
                        if (!r_we) r_rd_shift <= {r_rd_shift[15:0], w_dq_i};
                    end
                    if (w_last) begin
                        r_ck       <= 1'b0;
                        r_cnt      <= '0;
                        r_done_cnt <= r_done_lat;
                        if (!r_we) begin
                            r_data_in    <= {r_rd_shift, w_dq_i};
                            r_read_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_ck <= 1'b0;
                    if (r_done_cnt != '0) r_done_cnt <= r_done_cnt - 6'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef HYPERRAM_ASSERT_EN
    a_cs_idle_quiet: assert property (@(posedge clk) disable iff (!rst)
        cs_n |-> (!r_ck && !w_dq_oe && !w_rwds_oe));
    a_state_legal: assert property (@(posedge clk) disable iff (!rst)
        r_state inside {ST_IDLE, ST_CA, ST_WAIT, ST_DATA, ST_DONE});
    a_wait_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        (r_state == ST_WAIT) |-> (r_wait_cnt != '0));
    a_ca_cnt_range: assert property (@(posedge clk) disable iff (!rst)
        (r_state == ST_CA) |-> (r_cnt < 3'(CA_BYTES)));
    a_data_cnt_range: assert property (@(posedge clk) disable iff (!rst)
        (r_state == ST_DATA) |-> (r_cnt < 3'(DATA_BYTES)));
    c_write_done: cover property (@(posedge clk) disable iff (!rst) w_last && r_we);
    c_read_done:  cover property (@(posedge clk) disable iff (!rst) w_last && !r_we);
`else
    // Checking logic compiled out.
`endif

endmodule

// File: tb/tb_hyperram_controller.sv
// Scoreboard bench for hyperram_controller: transactions are queued as they are issued
// and a negedge monitor checks CA bytes, write beats, cs_n length and read words.
module tb_hyperram_controller;

    typedef struct {
        logic [47:0] ca;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          doff;
        int          len;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        transaction_begin = 1'b0;
    logic        write_enable = 1'b0;
    logic        timed_read = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  write_mask = '0;
    logic [5:0]  wait_latency = '0;
    logic [5:0]  done_latency = '0;
    logic [31:0] data_out = '0;
    logic [31:0] data_in;
    logic        read_valid;
    logic        busy;
    logic        ck;
    logic        cs_n;
    wire  [7:0]  dq;
    wire         rwds;

    logic        tb_dq_oe = 1'b0;
    logic [7:0]  tb_dq = '0;
    logic        tb_rwds_oe = 1'b0;
    logic        tb_rwds = 1'b0;

    assign dq   = tb_dq_oe   ? tb_dq   : 8'hzz;
    assign rwds = tb_rwds_oe ? tb_rwds : 1'bz;

    int n_vec  = 0;
    int n_miss = 0;

    txn_t        txq[$];
    logic [31:0] wq[$];
    txn_t        cur;
    int          mon_c = -1;
    logic [47:0] mon_sh;

    hyperram_controller dut (
        .clk               (clk),
        .rst               (rst),
        .transaction_begin (transaction_begin),
        .write_enable      (write_enable),
        .timed_read        (timed_read),
        .address           (address),
        .write_mask        (write_mask),
        .wait_latency      (wait_latency),
        .done_latency      (done_latency),
        .data_out          (data_out),
        .data_in           (data_in),
        .read_valid        (read_valid),
        .busy              (busy),
        .ck                (ck),
        .cs_n              (cs_n),
        .dq                (dq),
        .rwds              (rwds)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_c = -1;
        end else begin
            if (!cs_n) begin
                if (mon_c < 0) begin
                    if (txq.size() == 0) begin
                        check_eq("unexpected_cs", 1, 0);
                        cur.ca = '0; cur.we = 0; cur.wdata = '0; cur.mask = '0;
                        cur.doff = 0; cur.len = 0;
                    end else begin
                        cur = txq.pop_front();
                    end
                    mon_c = 0;
                end
                if (mon_c < 6) begin
                    mon_sh = cur.ca >> (8 * (5 - mon_c));
                    check_eq("ca_byte", dq, mon_sh[7:0]);
                    check_eq("ck_toggle", ck, (mon_c % 2 == 0));
                end else if (cur.we && mon_c >= cur.doff && mon_c < cur.doff + 4) begin
                    mon_sh = {16'h0, cur.wdata} >> (8 * (3 - (mon_c - cur.doff)));
                    check_eq("wr_byte", dq, mon_sh[7:0]);
                    check_eq("wr_rwds", rwds, cur.mask[3 - (mon_c - cur.doff)]);
                end
                mon_c++;
            end else if (mon_c >= 0) begin
                check_eq("cs_len", mon_c, cur.len);
                check_eq("ck_low_cs_high", ck, 0);
                mon_c = -1;
            end
            if (read_valid) begin
                if (wq.size() == 0) check_eq("rv_spurious", 1, 0);
                else check_eq("rd_word", data_in, wq.pop_front());
            end
        end
    end

    task automatic run_txn(input bit we, input bit timed, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] mask, input int lat,
                           input int dl, input bit rwds_ca, input bit hold);
        txn_t        t;
        int          w, k, d, rv_cnt, dcnt;
        logic [31:0] sh;
        bit          done;
        w      = (lat == 0) ? 0 : (rwds_ca ? 4 * lat : 2 * lat);
        t.ca   = {~we, 1'b0, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        t.we   = we;
        t.wdata = data;
        t.mask = mask;
        t.doff = 6 + w;
        t.len  = t.doff + ((we || timed) ? 4 : 7);
        k = 0;
        while (busy && k < 400) begin @(negedge clk); k++; end
        if (busy) check_eq("idle_timeout", busy, 0);
        write_enable      = we;
        timed_read        = timed;
        address           = addr;
        data_out          = data;
        write_mask        = mask;
        wait_latency      = 6'(lat);
        done_latency      = 6'(dl);
        tb_rwds_oe        = 1'b1;
        tb_rwds           = rwds_ca;
        transaction_begin = 1'b1;
        txq.push_back(t);
        if (!we) wq.push_back(data);
        rv_cnt = 0;
        done   = 0;
        @(negedge clk);
        for (int c = 0; c < 400 && !done; c++) begin
            if (cs_n && c > 0) begin
                done = 1;
                transaction_begin = 1'b0;
            end else if (!hold) begin
                transaction_begin = 1'b0;
            end else begin
                address      = ~addr;
                data_out     = ~data;
                write_enable = ~we;
            end
            if (c == 2) begin
                tb_rwds    = 1'b0;
                tb_rwds_oe = !we;
            end
            if (!we && c >= 6) begin
                d = c - t.doff;
                tb_dq_oe = 1'b1;
                if (d < 0) begin
                    tb_dq = 8'hEE;
                end else if (timed) begin
                    sh = data >> (8 * (3 - d));
                    if (d < 4) tb_dq = sh[7:0];
                    else tb_dq_oe = 1'b0;
                end else if (d < 8) begin
                    sh = data >> (8 * (3 - d / 2));
                    tb_dq   = (d % 2 == 0) ? sh[7:0] : ~sh[7:0];
                    tb_rwds = ((d / 2) % 2 == 0);
                end else begin
                    tb_dq_oe = 1'b0;
                end
            end
            if (read_valid) begin
                rv_cnt++;
                check_eq("rv_cycle", c, t.len);
            end
            if (!done) @(negedge clk);
        end
        if (!done) check_eq("txn_timeout", 0, 1);
        transaction_begin = 1'b0;
        tb_dq_oe   = 1'b0;
        tb_rwds_oe = 1'b0;
        dcnt = 0;
        while (busy && dcnt < 100) begin dcnt++; @(negedge clk); end
        check_eq("done_cycles", dcnt, (dl == 0) ? 1 : dl);
        check_eq("rv_count", rv_cnt, we ? 0 : 1);
        @(negedge clk);
        check_eq("stay_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        tb_dq_oe   = 1'b1;
        tb_dq      = 8'h5A;
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_ck", ck, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rv", read_valid, 0);
        check_eq("rst_data_in", data_in, 0);
        check_eq("rst_dq_released", dq, 8'h5A);
        check_eq("rst_rwds_released", rwds, 1);
        rst = 1'b1;
        tb_dq_oe   = 1'b0;
        tb_rwds_oe = 1'b0;
        @(negedge clk);

        // we, timed, addr, data, mask, lat, dl, rwds_ca, hold
        run_txn(1, 1, 32'h12345678, 32'hCCCCDDDD, 4'b0000, 0, 0, 0, 0);
        run_txn(1, 1, 32'h12345678, 32'hCCCCDDDD, 4'b0101, 0, 2, 0, 0);
        run_txn(0, 1, 32'h12345678, 32'hDDDDCCCC, 4'b0000, 3, 1, 0, 0);
        run_txn(0, 1, 32'h0000_0010, 32'hA1B2C3D4, 4'b0000, 2, 0, 1, 0);
        run_txn(0, 0, 32'h8765_4321, 32'h55AA3CC3, 4'b0000, 1, 0, 0, 0);
        run_txn(1, 1, 32'hFFFF_FFFF, 32'h0BADF00D, 4'b1000, 1, 5, 1, 1);
        run_txn(0, 1, 32'h0000_0007, 32'h01020304, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Strobed read whose strobe never toggles must hang in DATA until reset.
        t.ca = {1'b1, 1'b0, 1'b1, 29'h0ACE_1234 >> 0, 13'd0, 3'd5};
        address      = {t.ca[44:16], 3'd5};
        t.we = 0; t.wdata = '0; t.mask = '0; t.doff = 8; t.len = 0;
        txq.push_back(t);
        write_enable = 1'b0;
        timed_read   = 1'b0;
        wait_latency = 6'd1;
        done_latency = 6'd0;
        tb_rwds_oe   = 1'b1;
        tb_rwds      = 1'b0;
        transaction_begin = 1'b1;
        @(negedge clk);
        transaction_begin = 1'b0;
        repeat (6) @(negedge clk);
        tb_dq_oe = 1'b1;
        tb_dq    = 8'h77;
        repeat (60) @(negedge clk);
        check_eq("hang_busy", busy, 1);
        check_eq("hang_cs_n", cs_n, 0);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_cs_n", cs_n, 1);
        check_eq("abort_ck", ck, 0);
        check_eq("abort_rv", read_valid, 0);
        tb_dq_oe   = 1'b0;
        tb_rwds_oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(1, 1, 32'h2468_ACE0, 32'hF00DCAFE, 4'b0010, 2, 1, 0, 0);

        check_eq("txq_drained", txq.size(), 0);
        check_eq("wq_drained", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
